// File: rtl/add64_pkg.sv
// Shared types and widths for the two-pass 64-bit adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package add64_pkg;

   localparam int HALF = 32;        // width of one adder pass, matches the CLA core
   localparam int W    = 2 * HALF;  // full operand width

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/add64_seq_if.sv
// Operand and result handshake bundle for add64_seq.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_ready, in_a, in_b, in_cin, in_sub   operand channel
//   out_valid, out_ready, out_sum, out_cout, out_ovf result channel
// master = upstream producer and downstream consumer; slave = the sequencer.
interface add64_seq_if;
   import add64_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

endinterface

// File: rtl/add64_seq_cla.sv
// 32-bit carry-look-ahead adder core: 4-bit lookahead groups chained by group carries.
// Latency: combinational.
// Backpressure: none.
//
// Ports: a, b (32-bit addends), cin (carry in), sum (32-bit), cout (carry out of bit 31).
module CLA_32bit_Adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;    // carry into each bit
   logic [8:0]  cb;   // carry into each 4-bit group

   always_comb begin
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      cb    = '0;
      cb[0] = cin;
      for (int k = 0; k < 8; k++) begin
         c[4*k]   = cb[k];
         c[4*k+1] = g[4*k] | (p[4*k] & cb[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cb[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & cb[k]);
         // group generate | group propagate & group carry-in
         cb[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cb[k]);
      end
      sum  = p ^ c;
      cout = cb[8];
   end

endmodule

// File: rtl/add64_seq.sv
// 64-bit add/subtract built from two passes through one 32-bit CLA core (low half, then high).
// Latency: result valid after the second clock edge following accept; one op per 3 cycles peak.
// Backpressure: result held stable until out_ready; in_ready only in IDLE or retiring DONE.
//
// Ports: clk, rst_n (async active-low), bus (add64_seq_if.slave: operand and result channels).
module add64_seq
   import add64_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   add64_seq_if.slave  bus
);

   state_e          state_q, state_d;

   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;        // already inverted for subtraction
   logic            c0_q;
   logic [HALF-1:0] sum_lo_q;
   logic            c32_q;

   logic [HALF-1:0] cla_a, cla_b, cla_sum;
   logic            cla_cin, cla_cout;
   logic            load_lo, load_hi;
   logic            accept;

   // Core inputs come only from operand registers, never straight from the ports.
   CLA_32bit_Adder u_cla (
      .a    (cla_a),
      .b    (cla_b),
      .cin  (cla_cin),
      .sum  (cla_sum),
      .cout (cla_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      cla_a         = a_q[HALF-1:0];
      cla_b         = b_q[HALF-1:0];
      cla_cin       = c0_q;
      load_lo       = 1'b0;
      load_hi       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = ST_LO;
         end
         ST_LO: begin
            load_lo = 1'b1;
            state_d = ST_HI;
         end
         ST_HI: begin
            cla_a   = a_q[W-1:HALF];
            cla_b   = b_q[W-1:HALF];
            cla_cin = c32_q;
            load_hi = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            // retiring the result frees the block in the same cycle
            bus.in_ready  = bus.out_ready;
            if (bus.out_ready) state_d = bus.in_valid ? ST_LO : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         b_q          <= '0;
         c0_q         <= 1'b0;
         sum_lo_q     <= '0;
         c32_q        <= 1'b0;
         bus.out_sum  <= '0;
         bus.out_cout <= 1'b0;
         bus.out_ovf  <= 1'b0;
      end else begin
         if (accept) begin
            a_q  <= bus.in_a;
            b_q  <= bus.in_sub ? ~bus.in_b : bus.in_b;
            c0_q <= bus.in_sub | bus.in_cin;
         end
         if (load_lo) begin
            sum_lo_q <= cla_sum;
            c32_q    <= cla_cout;
         end
         if (load_hi) begin
            bus.out_sum  <= {cla_sum, sum_lo_q};
            bus.out_cout <= cla_cout;
            // same-sign operands producing a result of the other sign
            bus.out_ovf  <= (a_q[W-1] == b_q[W-1]) && (cla_sum[HALF-1] != a_q[W-1]);
         end
      end
   end

endmodule

// File: tb/tb_add64_seq.sv
// Self-checking bench for add64_seq: directed corner cases plus random operations vs a model.
// Latency: checks result appears after the second edge following accept.
// Backpressure: exercises held out_ready, back-to-back accept and reset mid-operation.
module tb_add64_seq;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   add64_seq_if bus ();

   add64_seq u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Plain 65-bit arithmetic: subtraction is A + (2^64-1-B) + 1.
   task automatic model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, output logic [63:0] s, output logic co,
                        output logic ov);
      logic [64:0] full;
      logic [63:0] bb;
      logic        sa, sb, ss;
      bb   = sub ? (64'hFFFF_FFFF_FFFF_FFFF - b) : b;
      full = {1'b0, a} + {1'b0, bb} + (sub ? 65'd1 : {64'd0, cin});
      s    = full[63:0];
      co   = full[64];
      sa   = a[63];
      sb   = b[63];
      ss   = s[63];
      ov   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
   endtask

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, input int hold, input bit retire);
      logic [63:0] es;
      logic        ec, eo;
      model(a, b, cin, sub, es, ec, eo);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
      chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      // keep valid high with junk: must be ignored while busy
      bus.in_a = {$urandom, $urandom};
      bus.in_b = {$urandom, $urandom};
      bus.in_sub = 1'($urandom);
      @(negedge clk);
      chk("lo_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("lo_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
      chk("hi_out_valid", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("done_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("sum", bus.out_sum, es);
      chk("cout", {63'd0, bus.out_cout}, {63'd0, ec});
      chk("ovf", {63'd0, bus.out_ovf}, {63'd0, eo});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_sum", bus.out_sum, es);
         chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      end
      if (retire) begin
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1 bus.out_ready = 1'b0;
         @(negedge clk);
         chk("retired_valid", {63'd0, bus.out_valid}, 64'd0);
      end
   endtask

   initial begin
      logic [63:0] es;
      logic        ec, eo;
      vectors       = 0;
      miscompares   = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_out_sum", bus.out_sum, 64'd0);
      chk("rst_out_cout", {63'd0, bus.out_cout}, 64'd0);
      chk("rst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // directed corners
      do_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1);
      do_op(64'd5, 64'd7, 1'b1, 1'b1, 0, 1'b1);
      do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0, 1'b1);
      do_op(64'h1234_5678_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 0, 1'b1);

      // backpressure, then back-to-back accept in the retiring cycle
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 5, 1'b0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = 64'd2;
      bus.in_b      = 64'd3;
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      #1 chk("b2b_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      @(negedge clk);
      chk("b2b_lo_valid", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      chk("b2b_hi_valid", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      chk("b2b_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("b2b_sum", bus.out_sum, 64'd5);
      chk("b2b_cout", {63'd0, bus.out_cout}, 64'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;

      // random operations with random result stalls
      for (int n = 0; n < 40; n++) begin
         do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), 1'b1);
      end

      // leave a known nonzero result in the output register, then abort in HI
      do_op(64'd40, 64'd2, 1'b0, 1'b0, 0, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 64'h0123_4567_89AB_CDEF;
      bus.in_b     = 64'h1111_1111_1111_1111;
      bus.in_sub   = 1'b0;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("abort_out_sum", bus.out_sum, 64'd0);
      chk("abort_out_cout", {63'd0, bus.out_cout}, 64'd0);
      chk("abort_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_result", {63'd0, bus.out_valid}, 64'd0);
      end

      // block still works after the abort
      model(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, es, ec, eo);
      do_op(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 0, 1'b0);
      chk("post_abort_cout", {63'd0, bus.out_cout}, {63'd0, ec});
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
